// File: rtl/tie_queue_master.sv
// Queue exerciser: pushes a seeded word sequence into a TIE output queue and checks it back from
// a TIE input queue. Define TIE_QUEUE_MASTER_DISPLAY_EN to log pushes, pops and mismatches.
module tie_queue_master #(
  parameter logic [31:0] SEED = 32'h0000_1000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  WordCount,
  input  logic        PopEn,
  output logic        TIE_OUTQ1_PushReq,
  output logic [95:0] TIE_OUTQ1,
  input  logic        TIE_OUTQ1_Full,
  output logic        TIE_INQ1_PopReq,
  input  logic [95:0] TIE_INQ1,
  input  logic        TIE_INQ1_Empty,
  output logic        Busy,
  output logic        Done,
  output logic [7:0]  ErrCount
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  push_cnt_q, push_cnt_d;
  logic [7:0]  pop_cnt_q, pop_cnt_d;
  logic [7:0]  err_q, err_d;
  logic        push_req_q, push_req_d;
  logic        pop_req_q, pop_req_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [95:0] outq_q, outq_d;

  logic        start_ok;
  logic        push_acc;
  logic        pop_acc;
  logic        mismatch;
  logic [95:0] exp_pop;

  function automatic logic [95:0] gen_word(input logic [31:0] idx);
    logic [31:0] s;
    s = SEED + idx;
    return {s, ~s, s};
  endfunction

  assign start_ok = Start && (state_q != StRun);
  assign push_acc = (state_q == StRun) && push_req_q && !TIE_OUTQ1_Full;
  assign pop_acc  = (state_q == StRun) && pop_req_q && !TIE_INQ1_Empty;
  assign exp_pop  = gen_word({24'd0, pop_cnt_q});
  assign mismatch = pop_acc && (TIE_INQ1 != exp_pop);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          state_d = (WordCount == 8'd0) ? StDone : StRun;
        end
      end
      StRun: begin
        if ((push_cnt_q == cnt_q) && (pop_cnt_q == cnt_q)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // All outputs are registered; this block computes their next values.
  always_comb begin
    cnt_d      = cnt_q;
    push_cnt_d = push_cnt_q;
    pop_cnt_d  = pop_cnt_q;
    err_d      = err_q;
    outq_d     = outq_q;
    if (start_ok) begin
      cnt_d      = WordCount;
      push_cnt_d = 8'd0;
      pop_cnt_d  = 8'd0;
      err_d      = 8'd0;
      outq_d     = gen_word(32'd0);
    end else begin
      if (push_acc) begin
        push_cnt_d = push_cnt_q + 8'd1;
        outq_d     = gen_word({24'd0, push_cnt_q} + 32'd1);
      end
      if (pop_acc) begin
        pop_cnt_d = pop_cnt_q + 8'd1;
        if (mismatch && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end
      end
    end
    push_req_d = (state_d == StRun) && (push_cnt_d < cnt_d);
    pop_req_d  = (state_d == StRun) && (pop_cnt_d < cnt_d) && PopEn;
    busy_d     = (state_d == StRun);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt_q      <= 8'd0;
      push_cnt_q <= 8'd0;
      pop_cnt_q  <= 8'd0;
      err_q      <= 8'd0;
      outq_q     <= 96'd0;
      push_req_q <= 1'b0;
      pop_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      push_cnt_q <= push_cnt_d;
      pop_cnt_q  <= pop_cnt_d;
      err_q      <= err_d;
      outq_q     <= outq_d;
      push_req_q <= push_req_d;
      pop_req_q  <= pop_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign TIE_OUTQ1_PushReq = push_req_q;
  assign TIE_OUTQ1         = outq_q;
  assign TIE_INQ1_PopReq   = pop_req_q;
  assign Busy              = busy_q;
  assign Done              = done_q;
  assign ErrCount          = err_q;

`ifdef TIE_QUEUE_MASTER_DISPLAY_EN
  always @(posedge CLK) begin
    if (!Reset) begin
      if (push_acc) begin
        $display("%0t tie_queue_master push %0d data %h", $time, push_cnt_q, TIE_OUTQ1);
      end
      if (pop_acc) begin
        $display("%0t tie_queue_master pop %0d data %h", $time, pop_cnt_q, TIE_INQ1);
      end
      if (mismatch) begin
        $display("%0t tie_queue_master mismatch pop %0d got %h expected %h", $time, pop_cnt_q,
                 TIE_INQ1, exp_pop);
      end
    end
  end
`endif

endmodule
